// File: rtl/key_event_arbiter.sv
// Debounced key flag/value pairs -> PRESS/RELEASE/REPEAT events, one pending slot per key,
// shared onto a single valid/ready port through a round-robin arbiter.

module key_event_fsm #(
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic       key_clk,
  input  logic       key_rst_n,
  input  logic       flag,
  input  logic       value,
  output logic       held,
  output logic       raise,
  output logic [1:0] raise_type
);
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RPT = 2'd2} state_e;

  localparam logic [31:0] HOLD_LD = 32'(HOLD_CYC - 1);
  localparam logic [31:0] RPT_LD  = 32'(REPEAT_CYC - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  always_ff @(posedge key_clk or negedge key_rst_n) begin
    if (!key_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    raise      = 1'b0;
    raise_type = 2'b00;
    case (state_q)
      IDLE: begin
        if (flag && !value) begin
          raise      = 1'b1;
          raise_type = 2'b01;
          cnt_d      = HOLD_LD;
          state_d    = HOLD;
        end
      end
      HOLD, RPT: begin
        // release beats a coincident repeat; a pressed-while-held flag is a glitch
        if (flag && value) begin
          raise      = 1'b1;
          raise_type = 2'b10;
          state_d    = IDLE;
        end else if (cnt_q == '0) begin
          raise      = 1'b1;
          raise_type = 2'b11;
          cnt_d      = RPT_LD;
          state_d    = RPT;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign held = (state_q != IDLE);
endmodule

module key_event_arbiter #(
  parameter int unsigned NUM_KEYS   = 4,
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000,
  parameter int unsigned IDW        = 2
) (
  input  logic                key_clk,
  input  logic                key_rst_n,
  input  logic [NUM_KEYS-1:0] key_flag,
  input  logic [NUM_KEYS-1:0] key_value,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDW-1:0]      evt_id,
  output logic [1:0]          evt_type,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                evt_ovf
);
  logic [NUM_KEYS-1:0]      raise;
  logic [NUM_KEYS-1:0][1:0] raise_type;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_event_fsm #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_fsm (
      .key_clk   (key_clk),
      .key_rst_n (key_rst_n),
      .flag      (key_flag[i]),
      .value     (key_value[i]),
      .held      (key_held[i]),
      .raise     (raise[i]),
      .raise_type(raise_type[i])
    );
  end

  logic [NUM_KEYS-1:0]      slot_v_q, slot_v_d;
  logic [NUM_KEYS-1:0][1:0] slot_t_q, slot_t_d;
  logic [IDW-1:0]           rr_ptr_q, rr_ptr_d;
  logic                     evt_valid_q, evt_valid_d;
  logic [IDW-1:0]           evt_id_q, evt_id_d;
  logic [1:0]               evt_type_q, evt_type_d;
  logic                     evt_ovf_q, evt_ovf_d;

  logic                load, found;
  logic [IDW:0]        idx;
  logic [IDW-1:0]      gnt_id;
  logic [NUM_KEYS-1:0] gnt;

  // Round-robin scan starting at rr_ptr, wrapping at NUM_KEYS.
  always_comb begin
    load   = !evt_valid_q || evt_ready;
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_KEYS)) idx = idx - (IDW+1)'(NUM_KEYS);
      if (!found && slot_v_q[idx[IDW-1:0]]) begin
        found  = 1'b1;
        gnt_id = idx[IDW-1:0];
      end
    end
    for (int i = 0; i < int'(NUM_KEYS); i++)
      gnt[i] = load && found && (gnt_id == IDW'(i));
  end

  always_comb begin
    slot_v_d    = slot_v_q;
    slot_t_d    = slot_t_q;
    evt_ovf_d   = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_type_d  = evt_type_q;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (raise[i]) begin
        // a same-cycle grant empties the slot first, so only an ungranted full slot overflows
        if (slot_v_q[i] && !gnt[i]) evt_ovf_d = 1'b1;
        slot_v_d[i] = 1'b1;
        slot_t_d[i] = raise_type[i];
      end else if (gnt[i]) begin
        slot_v_d[i] = 1'b0;
      end
    end
    if (load) begin
      evt_valid_d = found;
      if (found) begin
        evt_id_d   = gnt_id;
        evt_type_d = slot_t_q[gnt_id];
        rr_ptr_d   = (gnt_id == IDW'(NUM_KEYS - 1)) ? '0 : gnt_id + IDW'(1);
      end
    end
  end

  always_ff @(posedge key_clk or negedge key_rst_n) begin
    if (!key_rst_n) begin
      slot_v_q    <= '0;
      slot_t_q    <= '0;
      rr_ptr_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_type_q  <= 2'b00;
      evt_ovf_q   <= 1'b0;
    end else begin
      slot_v_q    <= slot_v_d;
      slot_t_q    <= slot_t_d;
      rr_ptr_q    <= rr_ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_type_q  <= evt_type_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_type  = evt_type_q;
  assign evt_ovf   = evt_ovf_q;
endmodule
